// File: rtl/adc_pkg.sv
// Shared ADC definitions: sample width, sample type and accumulator sizing.
package adc_pkg;
    localparam int ADC_WIDTH = 12;

    typedef logic [ADC_WIDTH-1:0] adc_sample_t;

    function automatic int sum_width(input int w, input int l2d);
        return w + l2d;
    endfunction
endpackage

// File: rtl/adc_moving_average_if.sv
// Sample-in / average-out stream bundle of the moving-average filter.
interface adc_moving_average_if
    import adc_pkg::*;
#(
    parameter int WIDTH = ADC_WIDTH
);
    // Strobe-only streams with no back-pressure: sample_valid qualifies
    // sample_in for exactly the cycle it is high, and avg_valid likewise
    // qualifies avg_out; a consumer must take the data in that cycle.
    logic             sample_valid;
    logic [WIDTH-1:0] sample_in;
    logic             avg_valid;
    logic [WIDTH-1:0] avg_out;
    logic             primed;

    modport master (
        output sample_valid,
        output sample_in,
        input  avg_valid,
        input  avg_out,
        input  primed
    );

    modport slave (
        input  sample_valid,
        input  sample_in,
        output avg_valid,
        output avg_out,
        output primed
    );
endinterface

// File: rtl/avg_sample_ram.sv
// Single-clock window store: one write port and one registered read port that
// returns the previous contents when reading and writing the same address.
module avg_sample_ram #(
    parameter int WIDTH  = 12,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wr_data,
    output logic [WIDTH-1:0]  rd_data
);
    logic [WIDTH-1:0] mem_q [0:(1<<ADDR_W)-1];
    logic [WIDTH-1:0] rd_data_q;

    // No reset, so the array maps onto block RAM; both non-blocking
    // assignments see the pre-edge contents, giving old-data behaviour.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[addr];
        end
    end

    assign rd_data = rd_data_q;
endmodule

// File: rtl/adc_moving_average.sv
// Boxcar filter over the last 2**LOG2_DEPTH ADC samples: a running sum is
// updated with (new - evicted) and its upper bits form the truncated mean.
module adc_moving_average
    import adc_pkg::*;
#(
    parameter int WIDTH      = ADC_WIDTH,
    parameter int LOG2_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    adc_moving_average_if.slave  bus
);
    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int SUM_W = sum_width(WIDTH, LOG2_DEPTH);

    typedef logic [LOG2_DEPTH-1:0] ptr_t;
    typedef logic [LOG2_DEPTH:0]   cnt_t;
    typedef logic [SUM_W-1:0]      sum_t;
    typedef logic [WIDTH-1:0]      smp_t;

    localparam cnt_t DEPTH_CNT = cnt_t'(DEPTH);

    ptr_t wr_ptr_q,    wr_ptr_d;
    cnt_t fill_cnt_q,  fill_cnt_d;
    smp_t new_q,       new_d;
    logic v1_q,        v1_d;
    logic evict1_q,    evict1_d;
    logic full1_q,     full1_d;
    sum_t sum_q,       sum_d;
    logic v2_q,        v2_d;
    logic full2_q,     full2_d;
    smp_t avg_out_q,   avg_out_d;
    logic avg_valid_q, avg_valid_d;
    logic primed_q,    primed_d;
    smp_t old_data;
    smp_t sub_term;

    avg_sample_ram #(
        .WIDTH  (WIDTH),
        .ADDR_W (LOG2_DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (bus.sample_valid),
        .rd_en   (bus.sample_valid),
        .addr    (wr_ptr_q),
        .wr_data (bus.sample_in),
        .rd_data (old_data)
    );

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        fill_cnt_d  = fill_cnt_q;
        new_d       = new_q;
        v1_d        = bus.sample_valid;
        evict1_d    = evict1_q;
        full1_d     = full1_q;
        sum_d       = sum_q;
        v2_d        = v1_q;
        full2_d     = full2_q;
        avg_out_d   = avg_out_q;
        avg_valid_d = v2_q;
        primed_d    = primed_q;

        // S1: the RAM slot at wr_ptr holds a real sample only once the window
        // has filled; before that it is stale and must not be subtracted.
        if (bus.sample_valid) begin
            wr_ptr_d = wr_ptr_q + ptr_t'(1);
            if (fill_cnt_q != DEPTH_CNT) begin
                fill_cnt_d = fill_cnt_q + cnt_t'(1);
            end
            new_d    = bus.sample_in;
            evict1_d = (fill_cnt_q == DEPTH_CNT);
            full1_d  = (fill_cnt_q >= DEPTH_CNT - cnt_t'(1));
        end

        sub_term = evict1_q ? old_data : '0;
        if (v1_q) begin
            sum_d   = sum_q + sum_t'(new_q) - sum_t'(sub_term);
            full2_d = full1_q;
        end

        if (v2_q) begin
            avg_out_d = sum_q[SUM_W-1:LOG2_DEPTH];
            primed_d  = primed_q | full2_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            fill_cnt_q  <= '0;
            new_q       <= '0;
            v1_q        <= 1'b0;
            evict1_q    <= 1'b0;
            full1_q     <= 1'b0;
            sum_q       <= '0;
            v2_q        <= 1'b0;
            full2_q     <= 1'b0;
            avg_out_q   <= '0;
            avg_valid_q <= 1'b0;
            primed_q    <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            fill_cnt_q  <= fill_cnt_d;
            new_q       <= new_d;
            v1_q        <= v1_d;
            evict1_q    <= evict1_d;
            full1_q     <= full1_d;
            sum_q       <= sum_d;
            v2_q        <= v2_d;
            full2_q     <= full2_d;
            avg_out_q   <= avg_out_d;
            avg_valid_q <= avg_valid_d;
            primed_q    <= primed_d;
        end
    end

    assign bus.avg_out   = avg_out_q;
    assign bus.avg_valid = avg_valid_q;
    assign bus.primed    = primed_q;
endmodule

// File: tb/tb_adc_moving_average.sv
// Drives a 256-deep and a 4-deep filter with the same stream and checks both
// every cycle against a window-of-samples reference model.
module tb_adc_moving_average;
    import adc_pkg::*;

    localparam int W       = ADC_WIDTH;
    localparam int L2_A    = 8;
    localparam int DEPTH_A = 1 << L2_A;
    localparam int L2_B    = 2;
    localparam int DEPTH_B = 1 << L2_B;
    localparam int N_RAND  = 600;

    typedef struct packed {
        logic        v;
        adc_sample_t avg;
        logic        pr;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    adc_moving_average_if #(.WIDTH(W)) bus_a ();
    adc_moving_average_if #(.WIDTH(W)) bus_b ();

    adc_moving_average #(.WIDTH(W), .LOG2_DEPTH(L2_A)) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_a)
    );

    adc_moving_average #(.WIDTH(W), .LOG2_DEPTH(L2_B)) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_b)
    );

    int n_assert = 0;
    int n_fail   = 0;

    adc_sample_t hist_a[$], hist_b[$];
    int unsigned cnt_a, cnt_b;
    exp_t        exp_a_q[$], exp_b_q[$];
    adc_sample_t hold_avg_a, hold_avg_b;
    logic        hold_pr_a, hold_pr_b;

    bit          ramp_en = 1'b0;
    int unsigned ramp_n;
    int          cap_sel = 0;
    adc_sample_t cap_a_q[$], cap_b_q[$];
    adc_sample_t rand_seq [N_RAND];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        hist_a.delete(); hist_b.delete();
        exp_a_q.delete(); exp_b_q.delete();
        cnt_a = 0; cnt_b = 0;
        hold_avg_a = '0; hold_avg_b = '0;
        hold_pr_a = 1'b0; hold_pr_b = 1'b0;
    endtask

    task automatic check_outputs();
        exp_t ea, eb;
        ea = '0;
        eb = '0;
        if (exp_a_q.size() > 2) ea = exp_a_q.pop_front();
        if (exp_b_q.size() > 2) eb = exp_b_q.pop_front();
        if (ea.v) begin hold_avg_a = ea.avg; hold_pr_a = ea.pr; end
        if (eb.v) begin hold_avg_b = eb.avg; hold_pr_b = eb.pr; end
        chk("a_avg_valid", 32'(bus_a.avg_valid), 32'(ea.v));
        chk("a_avg_out",   32'(bus_a.avg_out),   32'(hold_avg_a));
        chk("a_primed",    32'(bus_a.primed),    32'(hold_pr_a));
        chk("b_avg_valid", 32'(bus_b.avg_valid), 32'(eb.v));
        chk("b_avg_out",   32'(bus_b.avg_out),   32'(hold_avg_b));
        chk("b_primed",    32'(bus_b.primed),    32'(hold_pr_b));
        if (ramp_en && bus_a.avg_valid) begin
            ramp_n++;
            chk("ramp_800", 32'(bus_a.avg_out), ramp_n * 8);
            chk("ramp_primed", 32'(bus_a.primed), 32'(ramp_n == DEPTH_A));
        end
        if (bus_a.avg_valid && cap_sel == 1) cap_a_q.push_back(bus_a.avg_out);
        if (bus_a.avg_valid && cap_sel == 2) cap_b_q.push_back(bus_a.avg_out);
    endtask

    // Called just after a falling edge; returns at the next falling edge.
    task automatic tick(input logic v, input adc_sample_t d);
        exp_t ea, eb;
        int unsigned s;
        ea = '0;
        eb = '0;
        bus_a.sample_valid = v; bus_a.sample_in = d;
        bus_b.sample_valid = v; bus_b.sample_in = d;
        if (v) begin
            hist_a.push_back(d);
            if (hist_a.size() > DEPTH_A) void'(hist_a.pop_front());
            s = 0;
            foreach (hist_a[i]) s += hist_a[i];
            cnt_a++;
            ea = '{v: 1'b1, avg: adc_sample_t'(s >> L2_A), pr: (cnt_a >= DEPTH_A)};
            hist_b.push_back(d);
            if (hist_b.size() > DEPTH_B) void'(hist_b.pop_front());
            s = 0;
            foreach (hist_b[i]) s += hist_b[i];
            cnt_b++;
            eb = '{v: 1'b1, avg: adc_sample_t'(s >> L2_B), pr: (cnt_b >= DEPTH_B)};
        end
        exp_a_q.push_back(ea);
        exp_b_q.push_back(eb);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, '0);
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        bus_a.sample_valid = 1'b0; bus_a.sample_in = '0;
        bus_b.sample_valid = 1'b0; bus_b.sample_in = '0;
        model_clear();
        #1;
        for (int i = 0; i < n; i++) begin
            chk("rst_a_valid",  32'(bus_a.avg_valid), 32'd0);
            chk("rst_a_avg",    32'(bus_a.avg_out),   32'd0);
            chk("rst_a_primed", 32'(bus_a.primed),    32'd0);
            chk("rst_b_avg",    32'(bus_b.avg_out),   32'd0);
            @(negedge clk);
        end
        reset_n = 1'b1;
        idle(2);
    endtask

    initial begin
        bus_a.sample_valid = 1'b0; bus_a.sample_in = '0;
        bus_b.sample_valid = 1'b0; bus_b.sample_in = '0;
        model_clear();
        @(negedge clk);

        // 1: ramp of 0x800 back-to-back
        do_reset(3);
        ramp_en = 1'b1;
        ramp_n  = 0;
        for (int i = 0; i < DEPTH_A; i++) tick(1'b1, 12'h800);
        idle(3);
        ramp_en = 1'b0;
        chk("t1_count",  ramp_n, DEPTH_A);
        chk("t1_final",  32'(bus_a.avg_out), 32'h800);
        chk("t1_primed", 32'(bus_a.primed),  32'd1);

        // 6: long idle holds the output
        idle(1000);
        chk("t6_hold",   32'(bus_a.avg_out), 32'h800);

        // 2: full-scale swing without wrap
        do_reset(2);
        for (int i = 0; i < DEPTH_A; i++) tick(1'b1, 12'h000);
        for (int i = 0; i < DEPTH_A; i++) tick(1'b1, 12'hFFF);
        idle(3);
        chk("t2_max",    32'(bus_a.avg_out), 32'hFFF);
        for (int i = 0; i < DEPTH_A; i++) tick(1'b1, 12'h000);
        idle(3);
        chk("t2_zero",   32'(bus_a.avg_out), 32'h000);

        // 3: four-deep truncation and eviction
        do_reset(2);
        tick(1'b1, 12'd1); tick(1'b1, 12'd2); tick(1'b1, 12'd2); tick(1'b1, 12'd2);
        idle(3);
        chk("t3_trunc",  32'(bus_b.avg_out), 32'd1);
        chk("t3_primed", 32'(bus_b.primed),  32'd1);
        tick(1'b1, 12'd6);
        idle(3);
        chk("t3_evict",  32'(bus_b.avg_out), 32'd3);

        // 4: random sequence, back-to-back then with gaps
        foreach (rand_seq[i]) rand_seq[i] = adc_sample_t'($urandom_range(0, 4095));
        do_reset(2);
        cap_sel = 1;
        foreach (rand_seq[i]) tick(1'b1, rand_seq[i]);
        idle(3);
        do_reset(2);
        cap_sel = 2;
        foreach (rand_seq[i]) begin
            tick(1'b1, rand_seq[i]);
            idle(int'($urandom_range(0, 5)));
        end
        idle(3);
        cap_sel = 0;
        chk("t4_len_a", cap_a_q.size(), N_RAND);
        chk("t4_len_b", cap_b_q.size(), N_RAND);
        for (int i = 0; i < N_RAND && i < cap_a_q.size() && i < cap_b_q.size(); i++)
            chk("t4_same", 32'(cap_b_q[i]), 32'(cap_a_q[i]));

        // 5: reset right behind an accepted sample while primed
        chk("t5_pre_primed", 32'(bus_a.primed), 32'd1);
        tick(1'b1, 12'hABC);
        do_reset(2);
        idle(4);
        for (int i = 0; i < 4; i++) tick(1'b1, 12'h400);
        idle(3);
        chk("t5_masked", 32'(bus_a.avg_out), 32'h010);
        chk("t5_primed", 32'(bus_a.primed),  32'd0);
        chk("t5_b_full", 32'(bus_b.avg_out), 32'h400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
